// File: rtl/stim_seq_ctrl.sv
// Piecewise step/ramp stimulus player driving one registered DAC code bus.
// Table is written while idle; playback runs segments back to back.
module stim_seq_ctrl #(
    parameter int NSEG   = 8,
    parameter int CODE_W = 8,
    parameter int DUR_W  = 16,
    parameter int SL_W   = 6,
    parameter logic [CODE_W-1:0] IDLE_CODE = '0
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      cfg_we,
    input  logic [$clog2(NSEG)-1:0]   cfg_addr,
    input  logic [DUR_W-1:0]          cfg_dur,
    input  logic [CODE_W-1:0]         cfg_level,
    input  logic [SL_W-1:0]           cfg_slope,
    input  logic                      cfg_ramp,
    input  logic [$clog2(NSEG):0]     num_seg,
    input  logic                      loop_en,
    input  logic                      start,
    input  logic                      abort,
    output logic [CODE_W-1:0]         code_out,
    output logic [$clog2(NSEG)-1:0]   seg_idx,
    output logic                      seg_strobe,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int AW = $clog2(NSEG);
    localparam int SW = ((CODE_W > SL_W) ? CODE_W : SL_W) + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DUR_W-1:0]    r_dur [NSEG];
    logic [CODE_W-1:0]   r_lvl [NSEG];
    logic [SL_W-1:0]     r_slp [NSEG];
    logic                r_rmp [NSEG];

    logic [CODE_W-1:0]   r_code;
    logic [AW-1:0]       r_idx;
    logic                r_strobe;
    logic                r_err;
    logic [DUR_W-1:0]    r_cnt;
    logic [AW:0]         r_nseg;
    logic                r_loop;

    logic [CODE_W-1:0]   w_code_nxt;
    logic [AW-1:0]       w_idx_nxt;
    logic                w_strobe_nxt;
    logic [DUR_W-1:0]    w_cnt_nxt;
    logic [AW:0]         w_nseg_nxt;
    logic                w_loop_nxt;
    logic                w_load;
    logic [AW-1:0]       w_load_idx;
    logic                w_last;
    logic [SL_W-1:0]     w_slp;
    logic signed [SW-1:0] w_sum;
    logic [CODE_W-1:0]   w_sat;

    // Ramp step in a wider signed domain so both rails can be detected.
    always_comb begin
        w_slp = r_slp[r_idx];
        w_sum = $signed({{(SW-CODE_W){1'b0}}, r_code})
              + $signed({{(SW-SL_W){w_slp[SL_W-1]}}, w_slp});
        if (w_sum[SW-1]) begin
            w_sat = '0;
        end else if (|w_sum[SW-2:CODE_W]) begin
            w_sat = '1;
        end else begin
            w_sat = w_sum[CODE_W-1:0];
        end
    end

    assign w_last = ({1'b0, r_idx} == (r_nseg - (AW+1)'(1)));

    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_idx_nxt    = r_idx;
        w_strobe_nxt = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_nseg_nxt   = r_nseg;
        w_loop_nxt   = r_loop;
        w_load       = 1'b0;
        w_load_idx   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (abort) begin
                    w_code_nxt = IDLE_CODE;
                end else if (start) begin
                    if (num_seg != '0) begin
                        w_state_nxt = S_RUN;
                        w_nseg_nxt  = num_seg;
                        w_loop_nxt  = loop_en;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_code_nxt  = IDLE_CODE;
                    w_idx_nxt   = '0;
                end else if (r_cnt == DUR_W'(1)) begin
                    if (!w_last) begin
                        w_load     = 1'b1;
                        w_load_idx = r_idx + AW'(1);
                    end else if (r_loop) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - DUR_W'(1);
                    if (r_rmp[r_idx]) begin
                        w_code_nxt = w_sat;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                if (abort) begin
                    w_code_nxt = IDLE_CODE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_load) begin
            w_idx_nxt    = w_load_idx;
            w_strobe_nxt = 1'b1;
            w_code_nxt   = r_lvl[w_load_idx];
            w_cnt_nxt    = (r_dur[w_load_idx] == '0) ? DUR_W'(1)
                                                     : r_dur[w_load_idx];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_code   <= IDLE_CODE;
            r_idx    <= '0;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_nseg   <= '0;
            r_loop   <= 1'b0;
        end else begin
            r_code   <= w_code_nxt;
            r_idx    <= w_idx_nxt;
            r_strobe <= w_strobe_nxt;
            r_err    <= cfg_we && (r_state == S_RUN);
            r_cnt    <= w_cnt_nxt;
            r_nseg   <= w_nseg_nxt;
            r_loop   <= w_loop_nxt;
        end
    end

    // Table is frozen during playback; writes are accepted otherwise.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < NSEG; i++) begin
                r_dur[i] <= '0;
                r_lvl[i] <= '0;
                r_slp[i] <= '0;
                r_rmp[i] <= 1'b0;
            end
        end else if (cfg_we && (r_state != S_RUN)) begin
            r_dur[cfg_addr] <= cfg_dur;
            r_lvl[cfg_addr] <= cfg_level;
            r_slp[cfg_addr] <= cfg_slope;
            r_rmp[cfg_addr] <= cfg_ramp;
        end
    end

    assign code_out   = r_code;
    assign seg_idx    = r_idx;
    assign seg_strobe = r_strobe;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign cfg_err    = r_err;

endmodule
